// File: rtl/microsequencer_param_if.sv
// rtl/microsequencer_param_if.sv - microstore/datapath bundle between control unit and sequencer
interface microsequencer_param_if #(
  parameter int AW      = 7,
  parameter int NCOND   = 4,
  parameter int CSEL_W  = 2,
  parameter int UWORD_W = 40
);
  localparam int CTRL_W = UWORD_W - 4 - CSEL_W - AW;

  logic [UWORD_W-1:0] uword;
  logic [AW-1:0]      decode_addr;
  logic [NCOND-1:0]   cond_in;
  logic               hold;
  logic [AW-1:0]      uaddr;
  logic [CTRL_W-1:0]  ctrl;
  logic [AW-1:0]      ctrl_addr;
  logic               stk_err;

  modport master (
    output uword, decode_addr, cond_in, hold,
    input  uaddr, ctrl, ctrl_addr, stk_err
  );

  modport slave (
    input  uword, decode_addr, cond_in, hold,
    output uaddr, ctrl, ctrl_addr, stk_err
  );
endinterface

// File: rtl/microsequencer_param.sv
// rtl/microsequencer_param.sv - parametrised microprogram sequencer with registered control field
// Optional return-address stack enabled by defining MICRO_STACK_EN.
module microsequencer_param #(
  parameter int AW          = 7,
  parameter int NCOND       = 4,
  parameter int CSEL_W      = 2,
  parameter int UWORD_W     = 40,
  parameter int RESET_ADDR  = 0,
  parameter int FETCH_ADDR  = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  Clk,
  input  logic                  Clr,
  microsequencer_param_if.slave bus
);
  localparam int CTRL_W = UWORD_W - 4 - CSEL_W - AW;
  localparam int NSEL   = 2 ** CSEL_W;

  typedef enum logic [2:0] {
    OP_INC     = 3'd0,
    OP_JUMP    = 3'd1,
    OP_DECODE  = 3'd2,
    OP_CBR     = 3'd3,
    OP_WAIT    = 3'd4,
    OP_CALL    = 3'd5,
    OP_RET     = 3'd6,
    OP_RESTART = 3'd7
  } seq_op_t;

  logic [AW-1:0]     r_uaddr;
  logic [CTRL_W-1:0] r_ctrl;
  logic [AW-1:0]     r_ctrl_addr;

  seq_op_t           w_seq_op;
  logic              w_cond_inv;
  logic [CSEL_W-1:0] w_cond_sel;
  logic [AW-1:0]     w_target;
  logic [CTRL_W-1:0] w_ctrl_f;
  logic [NSEL-1:0]   w_cond_pad;
  logic              w_cond;
  logic [AW-1:0]     w_inc;
  logic [AW-1:0]     w_next;

  assign w_seq_op   = seq_op_t'(bus.uword[UWORD_W-1 -: 3]);
  assign w_cond_inv = bus.uword[UWORD_W-4];
  assign w_cond_sel = bus.uword[UWORD_W-5 -: CSEL_W];
  assign w_target   = bus.uword[CTRL_W +: AW];
  assign w_ctrl_f   = bus.uword[CTRL_W-1:0];

  // Selects beyond NCOND land on zero-filled padding, so they read as a false condition.
  always_comb begin
    w_cond_pad            = '0;
    w_cond_pad[NCOND-1:0] = bus.cond_in;
  end

  assign w_cond = w_cond_pad[w_cond_sel] ^ w_cond_inv;
  assign w_inc  = r_uaddr + AW'(1);

`ifdef MICRO_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]   r_stack [0:(2**IDX_W)-1];
  logic [SP_W-1:0] r_sp;
  logic            r_stk_err;
  logic [SP_W-1:0] w_sp_m1;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;

  assign w_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_sp_m1 = r_sp - SP_W'(1);
`endif

  always_comb begin
    w_next = w_inc;
`ifdef MICRO_STACK_EN
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
`endif
    case (w_seq_op)
      OP_INC:     w_next = w_inc;
      OP_JUMP:    w_next = w_target;
      OP_DECODE:  w_next = bus.decode_addr;
      OP_CBR:     w_next = w_cond ? w_target : w_inc;
      OP_WAIT:    w_next = w_cond ? w_inc : r_uaddr;
      OP_CALL: begin
        w_next = w_target;
`ifdef MICRO_STACK_EN
        if (w_full) w_err_set = 1'b1;
        else        w_push    = 1'b1;
`endif
      end
      OP_RET: begin
`ifdef MICRO_STACK_EN
        if (w_empty) begin
          w_next    = AW'(FETCH_ADDR);
          w_err_set = 1'b1;
        end else begin
          w_next = r_stack[w_sp_m1[IDX_W-1:0]];
          w_pop  = 1'b1;
        end
`else
        w_next = AW'(FETCH_ADDR);
`endif
      end
      default:    w_next = AW'(FETCH_ADDR);
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_uaddr     <= AW'(RESET_ADDR);
      r_ctrl      <= '0;
      r_ctrl_addr <= AW'(RESET_ADDR);
    end else if (!bus.hold) begin
      r_uaddr     <= w_next;
      r_ctrl      <= w_ctrl_f;
      r_ctrl_addr <= r_uaddr;
    end
  end

`ifdef MICRO_STACK_EN
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else if (!bus.hold) begin
      if (w_push)    r_sp      <= r_sp + SP_W'(1);
      if (w_pop)     r_sp      <= w_sp_m1;
      if (w_err_set) r_stk_err <= 1'b1;
    end
  end

  // Entries above the pointer are don't-care, so the storage itself needs no reset.
  always_ff @(posedge Clk) begin
    if (!bus.hold && w_push) r_stack[r_sp[IDX_W-1:0]] <= w_inc;
  end

  assign bus.stk_err = r_stk_err;
`else
  assign bus.stk_err = 1'b0;
`endif

  assign bus.uaddr     = r_uaddr;
  assign bus.ctrl      = r_ctrl;
  assign bus.ctrl_addr = r_ctrl_addr;
endmodule

// File: tb/tb_microsequencer_param.sv
// tb/tb_microsequencer_param.sv - directed and random checks of microsequencer_param against a reference model
module tb_microsequencer_param;
  localparam int AW    = 7;
  localparam int NC    = 3;
  localparam int CS    = 2;
  localparam int UW    = 40;
  localparam int DEPTH = 4;
  localparam int FETCH = 1;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  always #5 Clk = ~Clk;

  microsequencer_param_if #(.AW(AW), .NCOND(NC), .CSEL_W(CS), .UWORD_W(UW)) bus ();

  microsequencer_param #(
    .AW(AW), .NCOND(NC), .CSEL_W(CS), .UWORD_W(UW),
    .RESET_ADDR(0), .FETCH_ADDR(FETCH), .STACK_DEPTH(DEPTH)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .bus(bus)
  );

  logic [UW-1:0] mem [128];
  assign bus.uword = mem[bus.uaddr];

  int total = 0;
  int bad   = 0;

  int          m_uaddr, m_caddr, m_err;
  logic [31:0] m_ctrl;
  int          m_stk[$];

  function automatic logic [UW-1:0] mk(int op, int inv, int sel, int tgt, int cf);
    return {op[2:0], inv[0], sel[1:0], tgt[6:0], cf[26:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".uaddr"},     32'(bus.uaddr),     m_uaddr);
    chk({tag, ".ctrl"},      32'(bus.ctrl),      m_ctrl);
    chk({tag, ".ctrl_addr"}, 32'(bus.ctrl_addr), m_caddr);
    chk({tag, ".stk_err"},   32'(bus.stk_err),   m_err);
  endtask

  // Next state from the field rules, using plain integers and a queue for the stack.
  task automatic model_step();
    logic [UW-1:0] w;
    int op, inv, sel, tgt, c, inc, nxt, cin;
    if (bus.hold) return;
    w   = mem[m_uaddr];
    op  = int'(w[39:37]);
    inv = int'(w[36]);
    sel = int'(w[35:34]);
    tgt = int'(w[33:27]);
    cin = int'(bus.cond_in);
    c   = ((sel < NC) ? ((cin >> sel) & 1) : 0) ^ inv;
    inc = (m_uaddr + 1) % 128;
    case (op)
      0: nxt = inc;
      1: nxt = tgt;
      2: nxt = int'(bus.decode_addr);
      3: nxt = c ? tgt : inc;
      4: nxt = c ? inc : m_uaddr;
      5: begin
        nxt = tgt;
`ifdef MICRO_STACK_EN
        if (m_stk.size() < DEPTH) m_stk.push_back(inc);
        else m_err = 1;
`endif
      end
      6: begin
`ifdef MICRO_STACK_EN
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else begin nxt = FETCH; m_err = 1; end
`else
        nxt = FETCH;
`endif
      end
      default: nxt = FETCH;
    endcase
    m_caddr = m_uaddr;
    m_ctrl  = {5'b0, w[26:0]};
    m_uaddr = nxt;
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    Clr = 1'b0;
    #1;
    m_uaddr = 0; m_caddr = 0; m_ctrl = 0; m_err = 0;
    m_stk.delete();
    check_all(tag);
    @(negedge Clk);
    Clr = 1'b1;
  endtask

  initial begin
    logic [63:0] rnd;
    for (int i = 0; i < 128; i++) mem[i] = mk(0, 0, 0, 0, 32'h100 + i);
    bus.decode_addr = '0;
    bus.cond_in     = '0;
    bus.hold        = 1'b0;
    m_uaddr = 0; m_caddr = 0; m_ctrl = 0; m_err = 0;
    #1;
    check_all("por");
    @(negedge Clk);
    Clr = 1'b1;

    // async reset from uaddr 5
    for (int i = 0; i < 5; i++) step("inc_chain");
    chk("pre_reset_uaddr", 32'(bus.uaddr), 5);
    #2;
    do_reset("mid_reset");
    chk("reset_uaddr", 32'(bus.uaddr), 0);
    chk("reset_ctrl", 32'(bus.ctrl), 0);

    // INC then DECODE
    mem[1] = mk(2, 0, 0, 0, 32'h11);
    mem[67] = mk(0, 0, 0, 0, 32'h123);
    bus.decode_addr = 7'd67;
    step("inc0");
    chk("inc0_uaddr", 32'(bus.uaddr), 1);
    step("decode");
    chk("decode_uaddr", 32'(bus.uaddr), 67);
    step("ctrl_lag");
    chk("lag_ctrl", 32'(bus.ctrl), 32'h123);
    chk("lag_ctrl_addr", 32'(bus.ctrl_addr), 67);

    // WAIT on cond 0, then inverted polarity
    mem[68] = mk(4, 0, 0, 0, 32'h44);
    mem[69] = mk(4, 1, 0, 0, 32'h45);
    bus.cond_in = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step("wait_stall");
      chk("wait_stall_uaddr", 32'(bus.uaddr), 68);
    end
    bus.cond_in = 3'b001;
    step("wait_go");
    chk("wait_go_uaddr", 32'(bus.uaddr), 69);
    step("waitinv_stall");
    chk("waitinv_stall_uaddr", 32'(bus.uaddr), 69);
    bus.cond_in = 3'b000;
    step("waitinv_go");
    chk("waitinv_go_uaddr", 32'(bus.uaddr), 70);

    // CBR taken / not taken, out-of-range select, wrap
    mem[70]  = mk(3, 0, 1, 80, 32'h70);
    mem[80]  = mk(3, 0, 1, 10, 32'h80);
    mem[81]  = mk(3, 0, 3, 5, 32'h81);
    mem[82]  = mk(1, 0, 0, 127, 32'h82);
    mem[127] = mk(0, 0, 0, 0, 32'h7f);
    bus.cond_in = 3'b010;
    step("cbr_taken");
    chk("cbr_taken_uaddr", 32'(bus.uaddr), 80);
    bus.cond_in = 3'b000;
    step("cbr_not");
    chk("cbr_not_uaddr", 32'(bus.uaddr), 81);
    bus.cond_in = 3'b111;
    step("cbr_sel3");
    chk("cbr_sel3_uaddr", 32'(bus.uaddr), 82);
    step("jump127");
    step("wrap");
    chk("wrap_uaddr", 32'(bus.uaddr), 0);

    // hold freezes everything
    mem[1] = mk(0, 0, 0, 0, 32'h101);
    step("h_inc1");
    step("h_inc2");
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("hold");
      chk("hold_uaddr", 32'(bus.uaddr), 2);
      chk("hold_ctrl_addr", 32'(bus.ctrl_addr), 1);
    end
    bus.hold = 1'b0;
    step("hold_resume");
    chk("resume_uaddr", 32'(bus.uaddr), 3);

    // CALL / RET
    mem[3]  = mk(1, 0, 0, 10, 32'h3);
    mem[10] = mk(5, 0, 0, 40, 32'ha);
    mem[40] = mk(6, 0, 0, 0, 32'h28);
    step("jump10");
    step("call");
    chk("call_uaddr", 32'(bus.uaddr), 40);
    step("ret");
`ifdef MICRO_STACK_EN
    chk("ret_uaddr", 32'(bus.uaddr), 11);
`else
    chk("ret_uaddr", 32'(bus.uaddr), FETCH);
`endif

    // nested calls beyond depth
    do_reset("reset_nest");
    mem[0] = mk(1, 0, 0, 20, 32'h0);
    for (int i = 20; i < 25; i++) mem[i] = mk(5, 0, 0, i + 1, i);
    mem[25] = mk(0, 0, 0, 0, 32'h19);
    for (int i = 0; i < 6; i++) step("nest");
    chk("nest_uaddr", 32'(bus.uaddr), 25);
`ifdef MICRO_STACK_EN
    chk("nest_err", 32'(bus.stk_err), 1);
`else
    chk("nest_err", 32'(bus.stk_err), 0);
`endif

    // RET on empty stack
    do_reset("reset_empty");
    chk("err_cleared", 32'(bus.stk_err), 0);
    mem[0]  = mk(1, 0, 0, 50, 32'h0);
    mem[50] = mk(6, 0, 0, 0, 32'h32);
    step("jump50");
    step("ret_empty");
    chk("ret_empty_uaddr", 32'(bus.uaddr), FETCH);
`ifdef MICRO_STACK_EN
    chk("ret_empty_err", 32'(bus.stk_err), 1);
`else
    chk("ret_empty_err", 32'(bus.stk_err), 0);
`endif

    // random microprogram
    do_reset("reset_rand");
    for (int i = 0; i < 128; i++) begin
      rnd = {$urandom(), $urandom()};
      mem[i] = rnd[UW-1:0];
    end
    for (int n = 0; n < 400; n++) begin
      bus.cond_in     = 3'($urandom());
      bus.decode_addr = 7'($urandom());
      bus.hold        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2;
        do_reset("rand_reset");
      end
      step("rand");
    end
    bus.hold = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
